// File: rtl/seq_mult_unit.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement signed,
// one multiplier bit per clock with a start/busy/done handshake.
module seq_mult_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW:0]       acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [PW-1:0]     product_q, product_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    sum;

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits exactly
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1'b1)) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1'b1)) : b;
    sum   = acc_q[PW:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          done_d    = 1'b1;
          product_d = neg_q ? (~acc_q[PW-1:0] + PW'(1'b1)) : acc_q[PW-1:0];
        end else begin
          acc_d    = {sum, acc_q[WIDTH-1:0]} >> 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;

endmodule
